// File: rtl/mux_sel_pkg.sv
// Shared definitions for the mux select arbiter.
//   CH_N   : number of mux channels (4)
//   IDX_W  : width of a channel index (2)
//   state_e: arbiter FSM states
//   onehot : channel index -> one-hot grant vector
package mux_sel_pkg;

  localparam int CH_N  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [CH_N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [CH_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req    [3:0] in  : per-channel requests
//   ptr    [1:0] in  : highest-priority channel for this search
//   any          out : at least one request is set
//   idx    [1:0] out : winning channel (first set bit from ptr upward, mod 4)
//   gnt_oh [3:0] out : one-hot of idx, zero when no request
module rr_picker
  import mux_sel_pkg::*;
(
  input  logic [CH_N-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [CH_N-1:0]  gnt_oh
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    // Index arithmetic is IDX_W bits wide, so ptr+i wraps modulo CH_N.
    for (int i = 0; i < CH_N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt_oh = any ? onehot(idx) : '0;
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select sequencer driving the S1/S0 lines of a 4:1 data mux.
// Each grant is held for DWELL cycles; all outputs are registered.
//   clk        in  : rising-edge clock
//   rst_n      in  : asynchronous active-low reset
//   en         in  : arbitration enable (no new grant while low)
//   req  [3:0] in  : per-channel requests, bit i selects mux input Di
//   lock       in  : extend current grant at end of dwell (MUX_SEL_LOCK_EN only)
//   S0, S1     out : mux select, channel index bits 0/1
//   gnt  [3:0] out : one-hot grant, zero when idle
//   valid      out : grant active
//   done       out : one-cycle pulse in the first cycle after a grant ends
// Optional feature macro: MUX_SEL_LOCK_EN (adds the lock port).
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter  int DWELL = 4,                 // legal range 1..255
  localparam int CNT_W = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [CH_N-1:0] req,
`ifdef MUX_SEL_LOCK_EN
  input  logic            lock,
`endif
  output logic            S0,
  output logic            S1,
  output logic [CH_N-1:0] gnt,
  output logic            valid,
  output logic            done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CH_N-1:0]  gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [CH_N-1:0]  pick_oh;
  logic             lock_w;
  logic             can_arb;

`ifdef MUX_SEL_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  rr_picker u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .gnt_oh (pick_oh)
  );

  // Arbitration happens from IDLE, or at the last dwell cycle unless locked.
  assign can_arb = (state_q == IDLE) ||
                   ((state_q == HOLD) && (cnt_q == '0) && !lock_w);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if ((state_q == HOLD) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (can_arb) begin
      done_d = (state_q == HOLD);
      if (en && pick_any) begin
        state_d = HOLD;
        cnt_d   = CNT_W'(DWELL - 1);
        ptr_d   = pick_idx + IDX_W'(1);
        sel_d   = pick_idx;
        gnt_d   = pick_oh;
        valid_d = 1'b1;
      end else begin
        // Select lines keep the last index so the mux input stays put.
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    end
    // Otherwise: locked at end of dwell, everything holds.
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign S0    = sel_q[0];
  assign S1    = sel_q[1];
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule
